// File: rtl/instr_encoder.sv
// Sequential ARM-subset instruction encoder with a running byte address for imem fill.
// Optional macro INSTR_ENCODER_PC_REL_EN: branch req_value is an absolute byte target.
module instr_encoder #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_class,
    input  logic [3:0]            req_cmd,
    input  logic [3:0]            req_cond,
    input  logic                  req_set_flags,
    input  logic                  req_load,
    input  logic                  req_use_imm,
    input  logic [3:0]            req_rn,
    input  logic [3:0]            req_rd,
    input  logic [3:0]            req_rm,
    input  logic [31:0]           req_value,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_word,
    output logic                  out_error,
    output logic [ADDR_WIDTH-1:0] out_addr
);

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

`ifdef INSTR_ENCODER_PC_REL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, EMIT = 2'd2, CALC = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, EMIT = 2'd2} state_t;
`endif

    state_t                  state_q, state_d;
    logic [3:0]              rot_q, rot_d;
    logic [3:0]              cond_q, cond_d;
    logic [3:0]              cmd_q, cmd_d;
    logic                    s_q, s_d;
    logic [3:0]              rn_q, rn_d;
    logic [3:0]              rd_q, rd_d;
    logic [31:0]             value_q, value_d;
    logic [31:0]             out_word_q, out_word_d;
    logic                    out_error_q, out_error_d;
    logic [ADDR_WIDTH-1:0]   out_addr_q, out_addr_d;
    logic                    req_ready_q, req_ready_d;
    logic                    out_valid_q, out_valid_d;

    logic                    cmd_ok;
    logic [31:0]             mem_abs;
    logic [31:0]             acc_word;
    logic                    acc_err;
    logic                    acc_search;
    logic                    acc_calc;
    logic [4:0]              rol_amt;
    logic [31:0]             rot_val;
    logic                    rot_hit;

    // Classify and encode a request straight from the request inputs at accept time.
    always_comb begin
        cmd_ok     = (req_cmd == 4'b0100) || (req_cmd == 4'b0010) ||
                     (req_cmd == 4'b0000) || (req_cmd == 4'b1100);
        mem_abs    = req_value[31] ? (~req_value + 32'd1) : req_value;
        acc_word   = 32'h0;
        acc_err    = 1'b0;
        acc_search = 1'b0;
        acc_calc   = 1'b0;
        case (req_class)
            2'b00: begin
                if (!cmd_ok)
                    acc_err = 1'b1;
                else if (req_use_imm)
                    acc_search = 1'b1;
                else
                    acc_word = {req_cond, 2'b00, 1'b0, req_cmd, req_set_flags,
                                req_rn, req_rd, 8'h00, req_rm};
            end
            2'b01: begin
                if (req_use_imm) begin
                    if (mem_abs[31:12] != 20'h0)
                        acc_err = 1'b1;
                    else
                        acc_word = {req_cond, 2'b01, 1'b0, 1'b1, ~req_value[31], 2'b00,
                                    req_load, req_rn, req_rd, mem_abs[11:0]};
                end else begin
                    acc_word = {req_cond, 2'b01, 1'b1, 1'b1, 1'b1, 2'b00,
                                req_load, req_rn, req_rd, 8'h00, req_rm};
                end
            end
            2'b10: begin
`ifdef INSTR_ENCODER_PC_REL_EN
                acc_calc = 1'b1;
`else
                if ((req_value[31:23] != 9'h000) && (req_value[31:23] != 9'h1FF))
                    acc_err = 1'b1;
                else
                    acc_word = {req_cond, 4'b1010, req_value[23:0]};
`endif
            end
            default: acc_err = 1'b1;
        endcase
    end

    // A rotation of 2*rot left yields the candidate imm8 when the top 24 bits are clear.
    always_comb begin
        rol_amt = {rot_q, 1'b0};
        rot_val = (value_q << rol_amt) | (value_q >> (6'd32 - {1'b0, rol_amt}));
        rot_hit = (rot_val[31:8] == 24'h0);
    end

`ifdef INSTR_ENCODER_PC_REL_EN
    logic signed [31:0] br_diff;
    logic signed [31:0] br_off;
    logic               br_err;

    always_comb begin
        br_diff = $signed(value_q - 32'(out_addr_q) - 32'd8);
        br_off  = br_diff >>> 2;
        br_err  = (value_q[1:0] != 2'b00) ||
                  ((br_off[31:23] != 9'h000) && (br_off[31:23] != 9'h1FF));
    end
`endif

    always_comb begin
        state_d     = state_q;
        rot_d       = rot_q;
        cond_d      = cond_q;
        cmd_d       = cmd_q;
        s_d         = s_q;
        rn_d        = rn_q;
        rd_d        = rd_q;
        value_d     = value_q;
        out_word_d  = out_word_q;
        out_error_d = out_error_q;
        out_addr_d  = out_addr_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cond_d  = req_cond;
                    cmd_d   = req_cmd;
                    s_d     = req_set_flags;
                    rn_d    = req_rn;
                    rd_d    = req_rd;
                    value_d = req_value;
                    rot_d   = 4'd0;
                    if (acc_search) begin
                        state_d = SEARCH;
`ifdef INSTR_ENCODER_PC_REL_EN
                    end else if (acc_calc) begin
                        state_d = CALC;
`endif
                    end else begin
                        state_d     = EMIT;
                        out_word_d  = acc_err ? 32'h0 : acc_word;
                        out_error_d = acc_err;
                    end
                end
            end
            SEARCH: begin
                if (rot_hit) begin
                    state_d     = EMIT;
                    out_word_d  = {cond_q, 2'b00, 1'b1, cmd_q, s_q, rn_q, rd_q,
                                   rot_q, rot_val[7:0]};
                    out_error_d = 1'b0;
                end else if (rot_q == 4'd15) begin
                    state_d     = EMIT;
                    out_word_d  = 32'h0;
                    out_error_d = 1'b1;
                end else begin
                    rot_d = rot_q + 4'd1;
                end
            end
`ifdef INSTR_ENCODER_PC_REL_EN
            CALC: begin
                state_d     = EMIT;
                out_word_d  = br_err ? 32'h0 : {cond_q, 4'b1010, br_off[23:0]};
                out_error_d = br_err;
            end
`endif
            EMIT: begin
                if (out_ready) begin
                    state_d = IDLE;
                    if (!out_error_q)
                        out_addr_d = out_addr_q + ADDR_WIDTH'(4);
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
        out_valid_d = (state_d == EMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rot_q       <= 4'd0;
            cond_q      <= 4'd0;
            cmd_q       <= 4'd0;
            s_q         <= 1'b0;
            rn_q        <= 4'd0;
            rd_q        <= 4'd0;
            value_q     <= 32'h0;
            out_word_q  <= 32'h0;
            out_error_q <= 1'b0;
            out_addr_q  <= BASE;
            req_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rot_q       <= rot_d;
            cond_q      <= cond_d;
            cmd_q       <= cmd_d;
            s_q         <= s_d;
            rn_q        <= rn_d;
            rd_q        <= rd_d;
            value_q     <= value_d;
            out_word_q  <= out_word_d;
            out_error_q <= out_error_d;
            out_addr_q  <= out_addr_d;
            req_ready_q <= req_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign req_ready = req_ready_q;
    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_error = out_error_q;
    assign out_addr  = out_addr_q;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Sequential encoder for the inverse path of instruction decode: takes symbolic instruction fields and produces 32-bit ARM-subset machine words.
- Supported classes: data-processing ADD/SUB/AND/ORR (register or immediate), LDR/STR with immediate or register offset, and B.
- Used by the boot/program loader and by test infrastructure to fill instruction memory.
- Words leave with a running byte address, so a downstream writer stores each word directly into imem.

Parameters:
- ADDR_WIDTH, 8, width of out_addr byte-address counter.
- BASE_ADDR, 0, out_addr value after reset; must be a multiple of 4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request fields valid.
- req_ready  output  1  encoder can accept a request.
- req_class  input  2  00 data-processing, 01 memory, 10 branch, 11 illegal.
- req_cmd  input  4  DP command: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
- req_cond  input  4  condition field, copied to word[31:28].
- req_set_flags  input  1  DP S bit.
- req_load  input  1  memory: 1 LDR, 0 STR.
- req_use_imm  input  1  DP/memory: source 2 is req_value (1) or Rm (0).
- req_rn, req_rd, req_rm  input  4 each  register numbers.
- req_value  input  32  DP constant / signed memory offset / signed branch word offset.
- out_valid  output  1  out_word valid.
- out_ready  input  1  consumer accepts word.
- out_word  output  32  encoded instruction (0 on error).
- out_error  output  1  request was unencodable.
- out_addr  output  ADDR_WIDTH  byte address for out_word.

Behaviour:
- Reset state: IDLE; req_ready=1, out_valid=0, out_word=0, out_error=0, out_addr=BASE_ADDR.
- Reset asserted in any state aborts the operation in progress. The pending word is dropped and all outputs return to reset values on the next edge.
- FSM states: IDLE, SEARCH, EMIT. req_ready=1 only in IDLE. out_valid=1 only in EMIT.
- IDLE:
  - On req_valid, latch all req_* fields.
  - DP with req_use_imm=1 goes to SEARCH with rot=0.
  - All other requests encode combinationally from the latched fields and go to EMIT. out_valid is high 1 cycle after accept.
- SEARCH: one rotation tested per cycle, rot = 0..15.
  - Hit when (value ROL 2*rot)[31:8]==0. Then imm8 = (value ROL 2*rot)[7:0] and src2 = {rot, imm8}.
  - The lowest hit rot wins. A hit at rot k moves to EMIT, so out_valid rises k+2 cycles after accept.
  - No hit at rot 15 moves to EMIT with error, so out_valid rises 17 cycles after accept.
- DP encoding: {cond, 00, I, cmd, S, Rn, Rd, src2}.
  - Register form: I=0, src2={8'h00, Rm}.
  - Any other cmd, or req_class 11, is an error with no search.
- Memory encoding: {cond, 01, ~use_imm, P=1, U, B=0, W=0, L, Rn, Rd, src2}.
  - Immediate form: U = ~value[31]; src2 = |value| [11:0]. |value| >= 4096 is an error.
  - Register form: U=1, src2={8'h00, Rm}.
- Branch encoding: {cond, 1010, value[23:0]}. Error if value[31:23] is not all-equal (the offset does not fit in signed 24 bits).
- EMIT:
  - out_word, out_error and out_addr are held stable until out_valid & out_ready.
  - On that handshake the FSM returns to IDLE.
  - out_addr += 4 on the handshake only if out_error=0, wrapping modulo 2^ADDR_WIDTH.
- Error words: out_word=0, out_error=1, out_addr unchanged.
- No request is accepted in the same cycle as an output handshake; a new accept happens in IDLE the following cycle.

Optional Feature:
- Macro: INSTR_ENCODER_PC_REL_EN.
- Defined: for branches, req_value is an absolute byte target.
  - Encoder computes off = (target − (zero-extended out_addr + 8)) >>> 2.
  - Error if target[1:0] != 0 or off does not fit in signed 24 bits.
  - Takes one extra cycle: IDLE → CALC → EMIT, so branch out_valid is high 2 cycles after accept.
- Undefined: req_value is already the word offset; no CALC state exists.

Test Plan:
- ADD R1,R2,R3: cond E, cmd 0100, S=0, reg form → out_word 0xE0821003 one cycle after accept; out_addr 0x00. After handshake, out_addr becomes 0x04.
- SUBS R0,R0,#0xFF000000 (cond E) → rot=4, out_word 0xE25004FF; out_valid rises 6 cycles after accept. Constant 0x000000AB → 0xE25000AB at cycle 2.
- DP immediate 0x00000101 → out_error=1, out_word=0, out_valid at cycle 17; out_addr unchanged after handshake.
- LDR R4,[R5,#-8] → 0xE5154008. STR R4,[R5,#4] → 0xE5854004. Offset 4096 → error.
- Branch cond E, value 0xFFFFFFFE → 0xEAFFFFFE. Value 0x01000000 → error.
  - With INSTR_ENCODER_PC_REL_EN, out_addr=0x10, target 0x08 → 0xEAFFFFFC at cycle 2.
- Back-pressure and reset:
  - Hold out_ready=0 for 3 cycles → out_word stable, req_ready=0.
  - Assert reset during SEARCH → next cycle IDLE, out_valid=0, out_addr=BASE_ADDR.
